vc_allocator_rr: RTL

- Registered, stateful successor of the NIC's combinational VC allocator.
- Assigns router virtual channels to NIC output FIFOs with per-vnet round-robin fairness across requesters.
- Tracks VC ownership locally from grant until the tail flit is sent and the router reports the VC free again, so one VC can never be double-allocated.
- Sits between the fifo_nic2noc buffers and the router's free_signal lines.

---
 rtl/vc_allocator_rr_pkg.sv | 18 +
 rtl/vc_allocator_rr_if.sv | 27 ++
 rtl/vc_allocator_rr_vnet_rr_arbiter.sv | 39 +++
 rtl/vc_allocator_rr.sv | 97 +++++++++
 4 files changed

// File: rtl/vc_allocator_rr_pkg.sv
// nic_vc_pkg: shared VC state encoding, sizing constants and round-robin helper
package nic_vc_pkg;

    localparam int DEF_N_OF_VC = 2;
    localparam int DEF_N_OF_VN = 3;
    localparam int N_VC_TOTAL  = DEF_N_OF_VC * DEF_N_OF_VN;

    typedef enum logic [1:0] {
        VC_IDLE  = 2'd0,
        VC_OWNED = 2'd1,
        VC_DRAIN = 2'd2
    } vc_state_e;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/vc_allocator_rr_if.sv
// vc_allocator_rr_if: request/grant and router VC status bundle of the allocator
interface vc_allocator_rr_if #(
    parameter int N_OF_REQUEST   = 3,
    parameter int N_OF_VC        = 2,
    parameter int N_OF_VN        = 3,
    parameter int N_BITS_VNET_ID = 2,
    parameter int N_BITS_VC_ID   = N_OF_VC * N_OF_VN
);
    logic [N_OF_REQUEST-1:0]                r_va_i;
    logic [N_OF_REQUEST*N_BITS_VNET_ID-1:0] vnet_of_the_request_i;
    logic [N_OF_REQUEST-1:0]                g_va_o;
    logic [N_OF_REQUEST*N_BITS_VC_ID-1:0]   g_vc_id_o;
    logic [N_OF_VC*N_OF_VN-1:0]             tail_sent_i;
    logic [N_OF_VC*N_OF_VN-1:0]             free_signal_i;
    logic [N_OF_VC*N_OF_VN-1:0]             fifo_pointer_state_i;
    logic [N_OF_VC*N_OF_VN-1:0]             vc_owned_o;

    modport master (
        output r_va_i, vnet_of_the_request_i, tail_sent_i, free_signal_i, fifo_pointer_state_i,
        input  g_va_o, g_vc_id_o, vc_owned_o
    );

    modport slave (
        input  r_va_i, vnet_of_the_request_i, tail_sent_i, free_signal_i, fifo_pointer_state_i,
        output g_va_o, g_vc_id_o, vc_owned_o
    );
endinterface

// File: rtl/vc_allocator_rr_vnet_rr_arbiter.sv
// vnet_rr_arbiter: round-robin hand-out of one vnet's allocatable VCs to its requesters
module vnet_rr_arbiter
    import nic_vc_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int N_VC  = 2,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0]      req_i,
    input  logic [PW-1:0]         ptr_i,
    input  logic [N_VC-1:0]       free_i,
    output logic [N_REQ-1:0]      gnt_o,
    output logic [N_REQ*N_VC-1:0] vc_oh_o,
    output logic [PW-1:0]         ptr_o
);
    logic [N_VC-1:0] avail;
    logic [N_VC-1:0] low;
    int              idx;

    // scan from the pointer, each requester takes the lowest still-unclaimed VC
    always_comb begin
        avail   = free_i;
        low     = '0;
        idx     = 0;
        gnt_o   = '0;
        vc_oh_o = '0;
        ptr_o   = ptr_i;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_i) + i) % N_REQ;
            if (req_i[idx] && avail != '0) begin
                low                         = avail & (~avail + N_VC'(1));
                gnt_o[idx]                  = 1'b1;
                vc_oh_o[idx*N_VC +: N_VC]   = low;
                avail                       = avail & ~low;
                ptr_o                       = PW'(rr_next(idx, N_REQ));
            end
        end
    end
endmodule

// File: rtl/vc_allocator_rr.sv
// vc_allocator_rr: registered per-vnet round-robin VC allocator with local ownership tracking
module vc_allocator_rr
    import nic_vc_pkg::*;
#(
    parameter int N_OF_REQUEST   = 3,
    parameter int N_OF_VC        = DEF_N_OF_VC,
    parameter int N_OF_VN        = DEF_N_OF_VN,
    parameter int N_BITS_VNET_ID = 2,
    parameter int N_BITS_VC_ID   = N_OF_VC * N_OF_VN
) (
    input logic               clk,
    input logic               rst,
    vc_allocator_rr_if.slave  va_if
);
    localparam int NV = N_OF_VC * N_OF_VN;
    localparam int PW = (N_OF_REQUEST > 1) ? $clog2(N_OF_REQUEST) : 1;

    logic [N_OF_REQUEST-1:0]                     g_va_q, g_va_d;
    logic [N_OF_REQUEST*N_BITS_VC_ID-1:0]        g_vc_id_q, g_vc_id_d;
    logic [NV-1:0]                               alloc, granted, owned;
    vc_state_e                                   state_q [NV];
    vc_state_e                                   state_d [NV];
    logic [N_OF_VN-1:0][PW-1:0]                  ptr_q, ptr_d;
    logic [N_OF_VN-1:0][N_OF_REQUEST-1:0]        req, gnt;
    logic [N_OF_VN-1:0][N_OF_REQUEST*N_OF_VC-1:0] vc_oh;

    // requests split by vnet; requesters granted last cycle and out-of-range vnets are masked
    always_comb begin
        req = '0;
        for (int k = 0; k < N_OF_REQUEST; k++)
            for (int v = 0; v < N_OF_VN; v++)
                req[v][k] = va_if.r_va_i[k] && !g_va_q[k] &&
                            int'(va_if.vnet_of_the_request_i[k*N_BITS_VNET_ID +: N_BITS_VNET_ID]) == v;
    end

    // a VC can be handed out only when idle here, free at the router and empty in the NIC
    always_comb begin
        alloc = '0;
        owned = '0;
        for (int v = 0; v < NV; v++) begin
            alloc[v] = state_q[v] == VC_IDLE && va_if.free_signal_i[v] && !va_if.fifo_pointer_state_i[v];
            owned[v] = state_q[v] != VC_IDLE;
        end
    end

    for (genvar g = 0; g < N_OF_VN; g++) begin : g_arb
        vnet_rr_arbiter #(.N_REQ(N_OF_REQUEST), .N_VC(N_OF_VC), .PW(PW)) u_arb (
            .req_i   (req[g]),
            .ptr_i   (ptr_q[g]),
            .free_i  (alloc[g*N_OF_VC +: N_OF_VC]),
            .gnt_o   (gnt[g]),
            .vc_oh_o (vc_oh[g]),
            .ptr_o   (ptr_d[g])
        );
    end

    // merge per-vnet decisions into global grant vectors and the set of VCs claimed this cycle
    always_comb begin
        g_va_d    = '0;
        g_vc_id_d = '0;
        granted   = '0;
        for (int v = 0; v < N_OF_VN; v++)
            for (int k = 0; k < N_OF_REQUEST; k++)
                if (gnt[v][k]) begin
                    g_va_d[k] = 1'b1;
                    g_vc_id_d[k*N_BITS_VC_ID + v*N_OF_VC +: N_OF_VC] = vc_oh[v][k*N_OF_VC +: N_OF_VC];
                    granted[v*N_OF_VC +: N_OF_VC] = granted[v*N_OF_VC +: N_OF_VC] | vc_oh[v][k*N_OF_VC +: N_OF_VC];
                end
    end

    // per-VC ownership: a tail wins over a same-cycle free, which is then not consumed
    always_comb begin
        for (int v = 0; v < NV; v++)
            state_d[v] = (state_q[v] == VC_IDLE  && granted[v])               ? VC_OWNED :
                         (state_q[v] == VC_OWNED && va_if.tail_sent_i[v])     ? VC_DRAIN :
                         (state_q[v] == VC_DRAIN && va_if.free_signal_i[v])   ? VC_IDLE  : state_q[v];
    end

    // registered grants, pointers and VC states; reset drops all ownership
    always_ff @(posedge clk) begin
        if (!rst) begin
            g_va_q    <= '0;
            g_vc_id_q <= '0;
            ptr_q     <= '0;
            for (int v = 0; v < NV; v++) state_q[v] <= VC_IDLE;
        end else begin
            g_va_q    <= g_va_d;
            g_vc_id_q <= g_vc_id_d;
            ptr_q     <= ptr_d;
            for (int v = 0; v < NV; v++) state_q[v] <= state_d[v];
        end
    end

    assign va_if.g_va_o     = g_va_q;
    assign va_if.g_vc_id_o  = g_vc_id_q;
    assign va_if.vc_owned_o = owned;
endmodule
